// File: rtl/cmp_pkg.sv
// Shared definitions for the frame min/max block: FSM state encoding and default widths.
package cmp_pkg;

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/mag_cmp_w.sv
// W-bit unsigned magnitude comparator: flags a>b, a==b, a<b.
module mag_cmp_w #(
    parameter int W = cmp_pkg::W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         gt,
    output logic         eq,
    output logic         lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/stream_minmax.sv
// Per-frame min/max/count of an unsigned sample stream; result is held until downstream takes it.
module stream_minmax
    import cmp_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [W-1:0]     m_max,
    output logic [W-1:0]     m_min,
    output logic [CNT_W-1:0] m_cnt
);

    state_t             state, state_nxt;
    logic               first_beat;
    logic [W-1:0]       max_r, min_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               accept;
    logic               gt_max, eq_max, lt_max;
    logic               gt_min, eq_min, lt_min;

    mag_cmp_w #(.W(W)) u_cmp_max (
        .a  (s_data),
        .b  (max_r),
        .gt (gt_max),
        .eq (eq_max),
        .lt (lt_max)
    );

    mag_cmp_w #(.W(W)) u_cmp_min (
        .a  (s_data),
        .b  (min_r),
        .gt (gt_min),
        .eq (eq_min),
        .lt (lt_min)
    );

    assign accept = s_valid && s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_nxt;
        end
    end

    // s_ready is gated by rst_n so upstream sees "not ready" for the whole reset window.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        m_valid   = 1'b0;
        case (state)
            ACCUM: begin
                s_ready = rst_n;
                if (accept && s_last) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    state_nxt = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_beat <= 1'b1;
            max_r      <= '0;
            min_r      <= '0;
            cnt_r      <= '0;
        end else if (accept) begin
            first_beat <= 1'b0;
            if (first_beat) begin
                max_r <= s_data;
                min_r <= s_data;
                cnt_r <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                if (gt_max) max_r <= s_data;
                if (lt_min) min_r <= s_data;
                if (cnt_r != {CNT_W{1'b1}}) cnt_r <= cnt_r + 1'b1;
            end
        end else if (state == HOLD && m_ready) begin
            first_beat <= 1'b1;
        end
    end

    assign m_max = max_r;
    assign m_min = min_r;
    assign m_cnt = cnt_r;

endmodule
